// File: rtl/instruction_store_pkg.sv
// instruction_store_pkg
//   Shared definitions for the writable instruction store:
//   - state_t      : controller states (INIT / RUN / LOAD / RELEASE)
//   - NOP_WORD     : word presented on the fetch port while the CPU is held
//   - DEFAULT_PROG : 8-word program preloaded when
//                    INSTRUCTION_STORE_DEFAULT_PROG_EN is defined
package instruction_store_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] NOP_WORD = 8'h00;

  localparam int DEFAULT_PROG_LEN = 8;

  localparam logic [7:0] DEFAULT_PROG [0:DEFAULT_PROG_LEN-1] = '{
    8'h41, 8'h45, 8'h04, 8'h05, 8'h88, 8'h52, 8'h0E, 8'hFE
  };

endpackage

// File: rtl/instruction_store_input_sync.sv
// input_sync_edge
//   Brings a raw board input (switch or button) into the clock domain
//   through SYNC_STAGES flops and flags its synchronized rising edge.
//   Ports:
//     clock, reset : system clock, asynchronous active-high reset
//     async_in     : raw board signal
//     level        : synchronized level (last synchronizer stage)
//     rise         : one-cycle pulse while level is 1 and was 0 last cycle
module input_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  // A button bounce shorter than one (slow) clock period collapses into a
  // single sampled transition, so this pulse fires once per press.
  assign rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/instruction_store.sv
// instruction_store
//   256x8 program memory serving the processor fetch port, with a
//   switch/button load path. The processor is held in reset (cpu_reset)
//   while a program is entered and for RELEASE_CYCLES cycles afterwards.
//   Optional feature macro: INSTRUCTION_STORE_DEFAULT_PROG_EN
//     defined   -> reset enters INIT and preloads the 8-word default program
//     undefined -> reset enters RELEASE, memory undefined until loaded
//   Ports:
//     clock, reset        : system clock, asynchronous active-high reset
//     instruction_address : fetch address from the processor PC
//     instruction         : fetched word (NOP_WORD unless in RUN)
//     load_mode           : raw switch, high requests LOAD
//     load_strobe         : raw button, each press writes one word
//     load_data           : raw switches holding the word to write
//     cpu_reset           : registered reset for the processor
//     load_count          : write pointer / words written since LOAD entry
//     overflow            : sticky, pointer wrapped during current LOAD
//     loading             : high in LOAD
module instruction_store
  import instruction_store_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] instruction_address,
  output logic [7:0] instruction,
  input  logic       load_mode,
  input  logic       load_strobe,
  input  logic [7:0] load_data,
  output logic       cpu_reset,
  output logic [7:0] load_count,
  output logic       overflow,
  output logic       loading
);

  localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RELEASE_CYCLES - 1);

  state_t            state_reg;
  logic              cpu_reset_reg;
  logic [7:0]        load_count_reg;
  logic              overflow_reg;
  logic              loading_reg;
  logic [RC_W-1:0]   release_cnt_reg;
`ifdef INSTRUCTION_STORE_DEFAULT_PROG_EN
  logic [2:0]        init_cnt_reg;
`endif

  logic mode_level, mode_rise_unused;
  logic strobe_level_unused, strobe_rise;

  logic [7:0] mem [0:255];
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  input_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (load_mode),
    .level    (mode_level),
    .rise     (mode_rise_unused)
  );

  input_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (load_strobe),
    .level    (strobe_level_unused),
    .rise     (strobe_rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
`ifdef INSTRUCTION_STORE_DEFAULT_PROG_EN
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
`else
      state_reg    <= ST_RELEASE;
`endif
      cpu_reset_reg   <= 1'b1;
      load_count_reg  <= '0;
      overflow_reg    <= 1'b0;
      loading_reg     <= 1'b0;
      release_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (mode_level) begin
            state_reg      <= ST_LOAD;
            load_count_reg <= '0;
            overflow_reg   <= 1'b0;
            loading_reg    <= 1'b1;
            cpu_reset_reg  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // A strobe landing with the mode fall is still written; the
          // state change below happens on the same edge.
          if (strobe_rise) begin
            load_count_reg <= load_count_reg + 8'd1;
            if (load_count_reg == 8'hFF) overflow_reg <= 1'b1;
          end
          if (!mode_level) begin
            state_reg       <= ST_RELEASE;
            loading_reg     <= 1'b0;
            release_cnt_reg <= '0;
          end
        end
        ST_RELEASE: begin
          if (release_cnt_reg == RC_LAST) begin
            state_reg       <= ST_RUN;
            cpu_reset_reg   <= 1'b0;
            release_cnt_reg <= '0;
          end else begin
            release_cnt_reg <= release_cnt_reg + 1'b1;
          end
        end
`ifdef INSTRUCTION_STORE_DEFAULT_PROG_EN
        ST_INIT: begin
          init_cnt_reg <= init_cnt_reg + 3'd1;
          if (init_cnt_reg == 3'd7) begin
            state_reg       <= ST_RELEASE;
            release_cnt_reg <= '0;
          end
        end
`endif
        default: begin
          state_reg       <= ST_RELEASE;
          cpu_reset_reg   <= 1'b1;
          loading_reg     <= 1'b0;
          release_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Single write port shared by the button load path and the preload.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_count_reg;
    mem_wdata = load_data;
    if (state_reg == ST_LOAD && strobe_rise) begin
      mem_we = 1'b1;
    end
`ifdef INSTRUCTION_STORE_DEFAULT_PROG_EN
    if (state_reg == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = {5'd0, init_cnt_reg};
      mem_wdata = DEFAULT_PROG[init_cnt_reg];
    end
`endif
  end

  // Memory contents survive reset on purpose: a reset aborts a load but
  // keeps words already entered.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Fetch is combinational so the processor sees its word in the same cycle.
  assign instruction = (state_reg == ST_RUN) ? mem[instruction_address] : NOP_WORD;

  assign cpu_reset  = cpu_reset_reg;
  assign load_count = load_count_reg;
  assign overflow   = overflow_reg;
  assign loading    = loading_reg;

endmodule

// File: tb/tb_instruction_store.sv
module tb_instruction_store;

  localparam int K_INSTR   = 0;
  localparam int K_CPURST  = 1;
  localparam int K_COUNT   = 2;
  localparam int K_OVF     = 3;
  localparam int K_LOADING = 4;

`ifdef INSTRUCTION_STORE_DEFAULT_PROG_EN
  localparam bit HAS_INIT   = 1'b1;
  localparam int BOOT_EDGES = 10;
`else
  localparam bit HAS_INIT   = 1'b0;
  localparam int BOOT_EDGES = 2;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instruction_address = 8'd0;
  logic [7:0] instruction;
  logic       load_mode = 1'b0;
  logic       load_strobe = 1'b0;
  logic [7:0] load_data = 8'd0;
  logic       cpu_reset;
  logic [7:0] load_count;
  logic       overflow;
  logic       loading;

  instruction_store #(.SYNC_STAGES(2), .RELEASE_CYCLES(2)) dut (
    .clock               (clock),
    .reset               (reset),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .load_mode           (load_mode),
    .load_strobe         (load_strobe),
    .load_data           (load_data),
    .cpu_reset           (cpu_reset),
    .load_count          (load_count),
    .overflow            (overflow),
    .loading             (loading)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] prog_ref [8] = '{8'h41, 8'h45, 8'h04, 8'h05, 8'h88, 8'h52, 8'h0E, 8'hFE};
  logic [7:0] m_mem   [256];
  bit         m_known [256];
  int         m_count;
  bit         m_ovf;

  always @(negedge clock) begin
    while (sb_q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_INSTR:   act = instruction;
        K_CPURST:  act = {7'd0, cpu_reset};
        K_COUNT:   act = load_count;
        K_OVF:     act = {7'd0, overflow};
        default:   act = {7'd0, loading};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: %02h", e.name, act);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [7:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic direct_check(input logic [7:0] act, input logic [7:0] exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ovf   = 1'b0;
    if (HAS_INIT) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i]   = prog_ref[i];
        m_known[i] = 1'b1;
      end
    end
  endtask

  task automatic model_write(input logic [7:0] d);
    m_mem[m_count]   = d;
    m_known[m_count] = 1'b1;
    if (m_count == 255) m_ovf = 1'b1;
    m_count = (m_count + 1) % 256;
  endtask

  task automatic fetch(input int a);
    if (m_known[a]) begin
      instruction_address = 8'(a);
      expect_val(K_INSTR, m_mem[a], $sformatf("fetch[%0d]", a));
      tick();
    end
  endtask

  task automatic press(input logic [7:0] d);
    load_data   = d;
    load_strobe = 1'b1;
    tick(); tick();
    load_strobe = 1'b0;
    tick(); tick();
  endtask

  task automatic enter_load();
    load_mode = 1'b1;
    tick(); tick();
    expect_val(K_LOADING, 8'd0, "loading_before_entry");
    tick();
    m_count = 0;
    m_ovf   = 1'b0;
    expect_val(K_LOADING, 8'd1, "loading_in_load");
    expect_val(K_CPURST, 8'd1, "cpu_reset_in_load");
    expect_val(K_INSTR, 8'h00, "nop_in_load");
  endtask

  task automatic leave_load();
    load_mode = 1'b0;
    tick(); tick();
    tick();
    expect_val(K_LOADING, 8'd0, "loading_in_release");
    tick();
    expect_val(K_CPURST, 8'd1, "cpu_reset_release_edge1");
    tick();
    expect_val(K_CPURST, 8'd0, "cpu_reset_release_edge2");
  endtask

  task automatic check_status(input string tag);
    expect_val(K_COUNT, 8'(m_count), {tag, "_load_count"});
    expect_val(K_OVF, {7'd0, m_ovf}, {tag, "_overflow"});
    tick();
  endtask

  task automatic boot_after_reset(input string tag);
    model_reset();
    for (int k = 1; k <= BOOT_EDGES; k++) begin
      tick();
      expect_val(K_CPURST, (k < BOOT_EDGES) ? 8'd1 : 8'd0,
                 $sformatf("%s_cpu_reset_edge%0d", tag, k));
    end
  endtask

  initial begin
    logic [7:0] d;
    int         n;
    int         saved_count;

    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    tick(); tick();
    expect_val(K_CPURST, 8'd1, "reset_cpu_reset");
    expect_val(K_COUNT, 8'd0, "reset_load_count");
    expect_val(K_OVF, 8'd0, "reset_overflow");
    expect_val(K_LOADING, 8'd0, "reset_loading");
    expect_val(K_INSTR, 8'h00, "reset_instruction");
    tick();
    reset = 1'b0;
    boot_after_reset("boot");
    tick();
    direct_check({7'd0, cpu_reset}, 8'd0, "boot_direct_cpu_reset");
    for (int a = 0; a < 8; a++) fetch(a);

    enter_load();
    press(8'hA5); model_write(8'hA5);
    press(8'h3C); model_write(8'h3C);
    leave_load();
    check_status("two_word");
    direct_check(load_count, 8'd2, "two_word_direct_load_count");
    fetch(0);
    fetch(1);

    enter_load();
    for (int i = 0; i < 257; i++) begin
      d = 8'($urandom_range(0, 255));
      press(d);
      model_write(d);
    end
    leave_load();
    check_status("overflow");
    direct_check(load_count, 8'd1, "overflow_direct_load_count");
    direct_check({7'd0, overflow}, 8'd1, "overflow_direct_flag");
    instruction_address = 8'd0;
    #1;
    direct_check(instruction, m_mem[0], "overflow_direct_mem0");
    fetch(0);
    fetch(1);
    fetch(255);

    for (int r = 0; r < 3; r++) begin
      enter_load();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom_range(0, 255));
        press(d);
        model_write(d);
      end
      leave_load();
      check_status($sformatf("rand%0d", r));
      for (int i = 0; i < n; i++) fetch(i);
      fetch(int'($urandom_range(0, 255)));
    end

    enter_load();
    press(8'h11); model_write(8'h11);
    d = 8'($urandom_range(0, 255));
    load_data   = d;
    load_mode   = 1'b0;
    load_strobe = 1'b1;
    tick(); tick();
    tick();
    model_write(d);
    expect_val(K_LOADING, 8'd0, "simul_loading");
    load_strobe = 1'b0;
    tick();
    tick();
    expect_val(K_CPURST, 8'd0, "simul_cpu_reset");
    tick();
    check_status("simul");
    fetch(0);
    fetch(1);

    enter_load();
    press(8'h22); model_write(8'h22);
    load_mode = 1'b0;
    tick();
    load_data   = 8'hEE;
    load_strobe = 1'b1;
    tick(); tick(); tick();
    load_strobe = 1'b0;
    tick(); tick(); tick();
    check_status("release_ignore");
    fetch(0);
    fetch(1);

    saved_count = m_count;
    for (int i = 0; i < 3; i++) press(8'($urandom_range(0, 255)));
    m_count = saved_count;
    check_status("run_ignore");
    fetch(0);
    fetch(1);

    enter_load();
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      press(d);
      model_write(d);
    end
    reset = 1'b1;
    load_mode = 1'b0;
    #1;
    expect_val(K_CPURST, 8'd1, "midload_reset_cpu_reset");
    expect_val(K_COUNT, 8'd0, "midload_reset_load_count");
    expect_val(K_LOADING, 8'd0, "midload_reset_loading");
    tick(); tick();
    reset = 1'b0;
    boot_after_reset("midload");
    tick();
    direct_check({7'd0, cpu_reset}, 8'd0, "midload_direct_cpu_reset");
    for (int a = 0; a < 3; a++) fetch(a);
    check_status("midload");

    tick(); tick();
    if (n_fail != 0) begin
      $display("FAIL summary: %0d failures", n_fail);
    end else begin
      $display("ok   summary: no failures");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_store.md
# instruction_store

Writable 256×8 program memory that answers the processor's instruction fetch port: it takes `instruction_address` and returns `instruction`. It also provides a switch-and-button load path so a program can be entered on the board without resynthesis. While a program is loaded, the store holds the processor in reset through `cpu_reset`, then releases it cleanly. It sits between the board switches/buttons and the processor's fetch interface, on the same divided `clock`.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `load_mode` and `load_strobe`.
- `RELEASE_CYCLES`, default 2: cycles `cpu_reset` stays high after leaving LOAD or INIT.
- `clock`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `instruction_address`, input, 8: fetch address from the processor PC.
- `instruction`, output, 8: fetched instruction word.
- `load_mode`, input, 1: raw switch; high requests load mode.
- `load_strobe`, input, 1: raw push button; each press writes one word.
- `load_data`, input, 8: raw switches holding the word to write.
- `cpu_reset`, output, 1: drives the processor `reset`.
- `load_count`, output, 8: current write pointer, i.e. the number of words written since LOAD entry, mod 256.
- `overflow`, output, 1: sticky flag; the write pointer wrapped past 255 during the current LOAD.
- `loading`, output, 1: high in LOAD state.

## Operation
- States are INIT, RUN, LOAD and RELEASE.
- Reset values:
  - State: INIT if `INSTRUCTION_STORE_DEFAULT_PROG_EN` is defined, else RELEASE.
  - `cpu_reset` = 1, `load_count` = 0, `overflow` = 0, `loading` = 0.
  - Release counter = 0, init counter = 0.
  - Memory array is not reset.
- `load_mode` and `load_strobe` each pass through SYNC_STAGES flops. A strobe event is a synchronized 0→1 edge, one cycle wide.
- RUN:
  - `instruction` = mem[`instruction_address`], combinational.
  - `cpu_reset` = 0.
  - Synchronized `load_mode` = 1 → LOAD; on that transition clear `load_count` and `overflow`.
- LOAD:
  - `cpu_reset` = 1, `loading` = 1, `instruction` = 8'h00.
  - On a strobe event: mem[`load_count`] ← `load_data`, sampled on the same edge; `load_count` increments.
  - 255→0 wrap sets `overflow`; writes continue and overwrite from address 0.
  - Synchronized `load_mode` = 0 → RELEASE.
  - If a strobe event and the `load_mode` fall land in the same cycle, the write completes first, then the state moves to RELEASE.
- RELEASE:
  - `cpu_reset` = 1, `instruction` = 8'h00, strobes ignored.
  - After RELEASE_CYCLES cycles → RUN.
- INIT (macro only):
  - Writes DEFAULT_PROG[i] to mem[i] for i = 0..7, one word per cycle.
  - `cpu_reset` = 1, `instruction` = 8'h00, all inputs ignored.
  - After i = 7 → RELEASE.
- `load_count` and `overflow` hold their values through RELEASE and RUN until the next LOAD entry.
- Reset mid-LOAD or mid-INIT aborts the operation. Words already written are retained, except that with the macro, addresses 0–7 are rewritten by INIT.

## Timing
- Fetch has zero-cycle latency from `instruction_address` to `instruction` in RUN.
- Pin to action, SYNC_STAGES = 2:
  - A `load_strobe` rise is written on the 3rd clock edge after the pin rises.
  - A `load_mode` rise reaches LOAD on the 3rd edge after the pin rises.
- `cpu_reset` falls exactly RELEASE_CYCLES edges after RELEASE entry.
- `cpu_reset` is registered and glitch-free.
- With the macro, `cpu_reset` first falls 8 + RELEASE_CYCLES edges after `reset` deasserts.
- The button needs no debounce beyond the slow `clock` (≥1 s period); a bounce within one period yields one event.

## Configuration
- `INSTRUCTION_STORE_DEFAULT_PROG_EN`:
  - Defined: INIT state is present and reset preloads the 8-word default program.
  - Undefined: INIT is absent, reset goes straight to RELEASE, and memory contents are undefined until loaded.

## Structure
- Package `instruction_store_pkg` holds:
  - State enum INIT/RUN/LOAD/RELEASE.
  - DEFAULT_PROG[0:7] = 8'h41, 8'h45, 8'h04, 8'h05, 8'h88, 8'h52, 8'h0E, 8'hFE.
  - Constant `NOP_WORD` = 8'h00.
- One sub-module, `input_sync_edge`: SYNC_STAGES synchronizer plus rising-edge detector. Instantiate it twice, for mode and strobe.

## Test plan
- Macro on, reset pulse:
  - `cpu_reset` = 1 for 10 edges, then 0.
  - Address 0 reads 8'h41; address 7 reads 8'hFE.
- Load path, RELEASE_CYCLES = 2:
  - Raise `load_mode`, strobe 8'hA5 then 8'h3C, drop `load_mode`.
  - `load_count` = 2, `cpu_reset` falls 2 edges after RELEASE entry.
  - Address 0 reads 8'hA5; address 1 reads 8'h3C.
- Overflow: 257 strobes in one LOAD → `overflow` = 1, `load_count` = 1, mem[0] holds the 257th word.
- Simultaneous events: strobe edge and `load_mode` fall land in the same synchronized cycle → word written, `load_count` increments, state goes to RELEASE.
- Reset mid-LOAD after 3 words, macro off:
  - Immediately `cpu_reset` = 1 and `load_count` = 0.
  - After RELEASE, addresses 0–2 keep the loaded words.
- Ignored strobes: strobes in RUN and RELEASE → memory and `load_count` unchanged.
